comparator_arbiter: RTL

Time-shared front end for the N-bit unsigned select-comparator: arbitrates up to NREQ requesters round-robin, sequences one compare at a time through a single registered compare stage, and returns each 1-bit result to the requester that issued it over a valid/ready handshake. It sits between the control-plane clients that need compares and the one comparator instance, so the comparator is never duplicated per client.

---
 rtl/comparator_pkg.sv | 48 ++++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/comparator_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// comparator_pkg
//   Shared definitions for the time-shared comparator front end:
//   - op-code constants for the 3-bit select field
//   - FSM state encoding used by comparator_arbiter
//   - cmp_eval(): the unsigned select-comparator itself
//
// cmp_eval works on CMP_MAX_W-bit operands.
// Callers zero-extend their N-bit operands into that width.
// Zero-extension leaves every unsigned relation unchanged.
// This lets one package function serve any operand width up to CMP_MAX_W.
package comparator_pkg;

  localparam int CMP_MAX_W = 64;

  localparam logic [2:0] CMP_FALSE = 3'b000;
  localparam logic [2:0] CMP_TRUE  = 3'b001;
  localparam logic [2:0] CMP_EQ    = 3'b010;
  localparam logic [2:0] CMP_NE    = 3'b011;
  localparam logic [2:0] CMP_GE    = 3'b100;
  localparam logic [2:0] CMP_LE    = 3'b101;
  localparam logic [2:0] CMP_LT    = 3'b110;
  localparam logic [2:0] CMP_GT    = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic cmp_eval(input logic [2:0]           sel,
                                    input logic [CMP_MAX_W-1:0] a,
                                    input logic [CMP_MAX_W-1:0] b);
    logic r;
    case (sel)
      CMP_FALSE: r = 1'b0;
      CMP_TRUE:  r = 1'b1;
      CMP_EQ:    r = (a == b);
      CMP_NE:    r = (a != b);
      CMP_GE:    r = (a >= b);
      CMP_LE:    r = (a <= b);
      CMP_LT:    r = (a <  b);
      CMP_GT:    r = (a >  b);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick.
//   Searches req starting at ptr+1 and wraps modulo NREQ.
//   Returns the first requester found, as a one-hot grant and as a binary index.
//   ptr is the index of the previous winner, so that requester has the
//   lowest priority on the next pick.
//
// Ports
//   req    in   NREQ          request vector
//   ptr    in   clog2(NREQ)   previous winner (must be < NREQ)
//   grant  out  NREQ          one-hot winner, all zero when req is zero
//   index  out  clog2(NREQ)   binary winner, 0 when req is zero
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int IDX_W = $clog2(NREQ);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    cand  = '0;
    grant = '0;
    index = '0;
    // The wrap is an explicit modulo.
    // For NREQ that is not a power of two, cand therefore never reaches NREQ.
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/comparator_arbiter.sv
// comparator_arbiter
//   Shares one registered unsigned select-comparator among NREQ requesters.
//   Requests are arbitrated round-robin and executed one at a time:
//   IDLE (grant) -> EXEC (compare) -> RESP (return).
//   Each result goes back to the requester that issued it.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   NREQ     requester i presents a compare
//   req_ready  out  NREQ     one-hot accept, only in IDLE
//   req_sel    in   3*NREQ   op code of requester i at [3i+2:3i]
//   req_a      in   N*NREQ   operand A of requester i at [Ni+N-1:Ni]
//   req_b      in   N*NREQ   operand B of requester i
//   rsp_valid  out  NREQ     result available for requester i (at most one bit)
//   rsp_ready  in   NREQ     requester i consumes its result
//   rsp_out    out  1        result bit, zero while no rsp_valid bit is set
//   busy       out  1        FSM not in IDLE
//
// N must not exceed comparator_pkg::CMP_MAX_W.
module comparator_arbiter
  import comparator_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_sel,
  input  logic [N*NREQ-1:0] req_a,
  input  logic [N*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              rsp_out,
  output logic              busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic             result;
  logic [NREQ-1:0]  rsp_valid_q;
  logic             busy_q;

  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             accept;

  logic [2:0]       sel_p0;
  logic [N-1:0]     a_p0;
  logic [N-1:0]     b_p0;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .index (grant_idx)
  );

  // The grant is offered only in IDLE.
  // It is also gated by rst_n: while reset is held nothing can be latched,
  // so a visible grant would falsely signal an accept.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  // ---- stage p0: capture the winning request's operands on accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      sel_p0 <= req_sel[3*int'(grant_idx) +: 3];
      a_p0   <= req_a[N*int'(grant_idx) +: N];
      b_p0   <= req_b[N*int'(grant_idx) +: N];
    end
  end

  // ---- control FSM: grant -> compare (p1 result) -> response handshake ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NREQ - 1);
      winner      <= '0;
      result      <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            winner <= grant_idx;
            ptr    <= grant_idx;
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          result      <= cmp_eval(sel_p0, CMP_MAX_W'(a_p0), CMP_MAX_W'(b_p0));
          rsp_valid_q <= ONE << winner;
          state       <= RESP;
        end
        RESP: begin
          // Only the owner of the result can complete the handshake.
          if (rsp_ready[winner]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = result & (|rsp_valid_q);
  assign busy      = busy_q;

endmodule
